uart_rx_frame: RTL

//  Receive side of the RS422 UART link, peer of the transmitter: deserialises frames of start, 8 data bits LSB first, parity bit, 1..2 stop bits.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_baud_tick.sv | 32 +++
 rtl/uart_rx_frame.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, oversampling constants and parity helper.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP1,
        STOP2,
        DONE
    } rx_state_t;

    localparam int OVERSAMPLE = 16;
    localparam int SAMP_W     = $clog2(OVERSAMPLE);
    localparam int SAMP_MID   = 8;
    localparam int DATA_W     = 8;

    // sel=1 gives the XOR of the data bits, sel=0 its complement.
    function automatic logic parity_bit(input logic [DATA_W-1:0] data, input logic sel);
        return sel ? ^data : ~^data;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-cycle pulse every DIV clocks, restartable via clr.
module uart_baud_tick #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clr || (cnt_q == CW'(DIV - 1))) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == CW'(DIV - 1));

endmodule

// File: rtl/uart_rx_frame.sv
// RS422 UART receiver: 16x oversampled frame deserialiser with valid/ack byte handshake.
// Optional build macro UART_RX_MAJORITY_EN selects 2-of-3 majority sampling around the bit centre.
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115200
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              parity,
    input  logic              stopbit,
    input  logic              rs422_rx,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ack,
    output logic              parity_err,
    output logic              frame_err,
    output logic              overrun,
    output logic              busy
);

    localparam int DIV_RAW = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;

    logic              meta_q, sync_q0, sync_q1;
    logic [1:0]        fill_q, fill_d;
    logic              fall, tick, baud_clr, centre, bit_val;
    rx_state_t         state_q, state_d;
    logic [SAMP_W-1:0] samp_cnt_q, samp_cnt_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] shreg_q, shreg_d, rx_data_q, rx_data_d;
    logic              p_err_q, p_err_d, f_err_q, f_err_d;
    logic              rx_valid_q, rx_valid_d, parity_err_q, parity_err_d;
    logic              frame_err_q, frame_err_d, overrun_q, overrun_d, busy_q, busy_d;

    uart_baud_tick #(.DIV(DIV)) u_baud_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (baud_clr),
        .tick (tick)
    );

    // Edges are only trusted once the pin has propagated through the whole chain,
    // so a line held low across reset cannot fake a start bit.
    assign fill_d = (fill_q == 2'd3) ? fill_q : fill_q + 2'd1;
    assign fall   = (fill_q == 2'd3) && sync_q1 && !sync_q0;

`ifdef UART_RX_MAJORITY_EN
    logic samp7_q, samp7_d, samp8_q, samp8_d;

    always_comb begin
        samp7_d = samp7_q;
        samp8_d = samp8_q;
        if (tick && (samp_cnt_q == SAMP_W'(SAMP_MID - 1))) samp7_d = sync_q0;
        if (tick && (samp_cnt_q == SAMP_W'(SAMP_MID)))     samp8_d = sync_q0;
    end

    always_ff @(posedge clk) begin
        samp7_q <= samp7_d;
        samp8_q <= samp8_d;
    end

    assign centre  = tick && (samp_cnt_q == SAMP_W'(SAMP_MID + 1));
    assign bit_val = (samp7_q & samp8_q) | (samp7_q & sync_q0) | (samp8_q & sync_q0);
`else
    assign centre  = tick && (samp_cnt_q == SAMP_W'(SAMP_MID));
    assign bit_val = sync_q0;
`endif

    always_comb begin
        state_d      = state_q;
        samp_cnt_d   = samp_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shreg_d      = shreg_q;
        p_err_d      = p_err_q;
        f_err_d      = f_err_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = rx_valid_q;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;
        overrun_d    = overrun_q;
        baud_clr     = 1'b0;

        // samp_cnt wraps freely through the frame so every centre stays one bit apart.
        if (tick && (state_q != IDLE)) samp_cnt_d = samp_cnt_q + SAMP_W'(1);

        case (state_q)
            IDLE: begin
                samp_cnt_d = '0;
                if (fall) begin
                    state_d  = START;
                    baud_clr = 1'b1;
                    p_err_d  = 1'b0;
                    f_err_d  = 1'b0;
                end
            end
            START: begin
                bit_cnt_d = '0;
                if (centre) state_d = bit_val ? IDLE : DATA;
            end
            DATA: begin
                if (centre) begin
                    shreg_d   = {bit_val, shreg_q[DATA_W-1:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = PARITY;
                end
            end
            PARITY: begin
                if (centre) begin
                    p_err_d = (bit_val != parity_bit(shreg_q, parity));
                    state_d = STOP1;
                end
            end
            STOP1: begin
                if (centre) begin
                    f_err_d = f_err_q | ~bit_val;
                    state_d = stopbit ? STOP2 : DONE;
                end
            end
            STOP2: begin
                if (centre) begin
                    f_err_d = f_err_q | ~bit_val;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (state_q == DONE) begin
            if (!rx_valid_q || rx_ack) begin
                rx_data_d    = shreg_q;
                parity_err_d = p_err_q;
                frame_err_d  = f_err_q;
                rx_valid_d   = 1'b1;
                overrun_d    = 1'b0;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (rx_valid_q && rx_ack) begin
            rx_valid_d = 1'b0;
            overrun_d  = 1'b0;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q       <= 1'b1;
            sync_q0      <= 1'b1;
            sync_q1      <= 1'b1;
            fill_q       <= '0;
            state_q      <= IDLE;
            samp_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            shreg_q      <= '0;
            p_err_q      <= 1'b0;
            f_err_q      <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            meta_q       <= rs422_rx;
            sync_q0      <= meta_q;
            sync_q1      <= sync_q0;
            fill_q       <= fill_d;
            state_q      <= state_d;
            samp_cnt_q   <= samp_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shreg_q      <= shreg_d;
            p_err_q      <= p_err_d;
            f_err_q      <= f_err_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
            busy_q       <= busy_d;
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;
    assign busy       = busy_q;

endmodule
